// File: rtl/nbit_universal_register.sv
// rtl/nbit_universal_register.sv - n-bit universal register: load, shift, rotate, increment, decrement
module nbit_universal_register #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [2:0]   mode,
  input  logic [n-1:0] in0,
  input  logic         sin_r,
  input  logic         sin_l,
  output logic [n-1:0] out0,
  output logic         cout,
  output logic         zero
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  logic [n-1:0] nxt;
  logic         nxt_c;
  logic [n:0]   inc_sum;

  assign inc_sum = {1'b0, out0} + {{n{1'b0}}, 1'b1};

  always_comb begin
    nxt   = out0;
    nxt_c = cout;
    case (mode)
      MODE_HOLD: begin
        nxt   = out0;
        nxt_c = cout;
      end
      MODE_LOAD: begin
        nxt   = in0;
        nxt_c = 1'b0;
      end
      MODE_SHL: begin
        nxt   = {out0[n-2:0], sin_r};
        nxt_c = out0[n-1];
      end
      MODE_SHR: begin
        nxt   = {sin_l, out0[n-1:1]};
        nxt_c = out0[0];
      end
      MODE_ROL: begin
        nxt   = {out0[n-2:0], out0[n-1]};
        nxt_c = out0[n-1];
      end
      MODE_ROR: begin
        nxt   = {out0[0], out0[n-1:1]};
        nxt_c = out0[0];
      end
      MODE_INC: begin
        nxt   = inc_sum[n-1:0];
        nxt_c = inc_sum[n];
      end
      MODE_DEC: begin
        // borrow only when wrapping from zero to all-ones
        nxt   = out0 - {{(n-1){1'b0}}, 1'b1};
        nxt_c = (out0 == '0);
      end
      default: begin
        nxt   = out0;
        nxt_c = cout;
      end
    endcase
  end

  genvar i;
  generate
    for (i = 0; i < n; i++) begin : g_bit
      logic q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          q <= 1'b0;
        else if (en)
          q <= nxt[i];
      end
      assign out0[i] = q;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cout <= 1'b0;
    else if (en)
      cout <= nxt_c;
  end

  assign zero = ~|out0;

endmodule

// File: tb/tb_nbit_universal_register.sv
// tb/tb_nbit_universal_register.sv - scoreboard bench for nbit_universal_register at n=2, 8, 32
module tb_nbit_universal_register;

  typedef struct packed {
    logic [2:0][63:0] v;
    logic [2:0]       c;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  mode;
  logic [31:0] in_d;
  logic        sin_r;
  logic        sin_l;

  logic [1:0]  out2;
  logic [7:0]  out8;
  logic [31:0] out32;
  logic        cout2, cout8, cout32;
  logic        zero2, zero8, zero32;

  exp_t             sb[$];
  logic [2:0][63:0] mv;
  logic [2:0]       mc;
  int               checks;
  int               failures;

  nbit_universal_register #(.n(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in0(in_d[1:0]),
    .sin_r(sin_r), .sin_l(sin_l), .out0(out2), .cout(cout2), .zero(zero2));
  nbit_universal_register #(.n(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in0(in_d[7:0]),
    .sin_r(sin_r), .sin_l(sin_l), .out0(out8), .cout(cout8), .zero(zero8));
  nbit_universal_register #(.n(32)) dut32 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in0(in_d),
    .sin_r(sin_r), .sin_l(sin_l), .out0(out32), .cout(cout32), .zero(zero32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wid(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 8 : 32);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: value treated as an unsigned integer modulo 2^w
  function automatic void model(input int w, input logic [63:0] v, input logic c,
                                input logic [2:0] m, input logic [63:0] d,
                                input logic sr, input logic sl,
                                output logic [63:0] nv, output logic nc);
    logic [63:0] full, half, top, s;
    full = 64'd1 << w;
    half = full / 2;
    top  = v / half;
    case (m)
      3'd1: begin nv = d % full;                   nc = 1'b0; end
      3'd2: begin nv = (v * 2 + 64'(sr)) % full;   nc = (top != 0); end
      3'd3: begin nv = v / 2 + 64'(sl) * half;     nc = (v % 2 != 0); end
      3'd4: begin nv = (v * 2 + top) % full;       nc = (top != 0); end
      3'd5: begin nv = v / 2 + (v % 2) * half;     nc = (v % 2 != 0); end
      3'd6: begin s = v + 1; nv = s % full;        nc = (s == full); end
      3'd7: begin nv = (v + full - 1) % full;      nc = (v == 0); end
      default: begin nv = v; nc = c; end
    endcase
  endfunction

  task automatic op(input logic r, input logic e, input logic [2:0] m,
                    input logic [31:0] d, input logic sr, input logic sl);
    exp_t x;
    logic [63:0] nv;
    logic nc;
    @(negedge clk);
    rst = r; en = e; mode = m; in_d = d; sin_r = sr; sin_l = sl;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        mv[k] = '0; mc[k] = 1'b0;
      end else if (e) begin
        model(wid(k), mv[k], mc[k], m, 64'(d), sr, sl, nv, nc);
        mv[k] = nv; mc[k] = nc;
      end
      x.v[k] = mv[k];
      x.c[k] = mc[k];
    end
    sb.push_back(x);
    @(posedge clk);
    #3;
    // inputs wander between edges; only the edge sample may matter
    mode = 3'($urandom); in_d = $urandom; sin_r = 1'($urandom);
    sin_l = 1'($urandom); en = 1'($urandom);
  endtask

  initial begin : monitor
    exp_t x;
    logic [2:0][63:0] av;
    logic [2:0] ac, az;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        av[0] = 64'(out2); av[1] = 64'(out8); av[2] = 64'(out32);
        ac = {cout32, cout8, cout2};
        az = {zero32, zero8, zero2};
        for (int k = 0; k < 3; k++) begin
          check($sformatf("out0_n%0d", wid(k)), av[k], x.v[k]);
          check($sformatf("cout_n%0d", wid(k)), 64'(ac[k]), 64'(x.c[k]));
          check($sformatf("zero_n%0d", wid(k)), 64'(az[k]), 64'(x.v[k] == 0));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    checks = 0; failures = 0;
    mv = '0; mc = '0;
    rst = 1'b0; en = 1'b0; mode = 3'd0; in_d = '0; sin_r = 1'b0; sin_l = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_out8", 64'(out8), 64'h0);
    check("reset_zero8", 64'(zero8), 64'h1);

    // async reset between edges, then reset dominance and restart from zero
    op(1'b0, 1'b1, 3'd1, 32'h000000A5, 1'b0, 1'b0);
    check("load_a5_n8", 64'(out8), 64'hA5);
    rst = 1'b1;
    mv = '0; mc = '0;
    #1;
    check("async_rst_out8", 64'(out8), 64'h0);
    check("async_rst_cout8", 64'(cout8), 64'h0);
    check("async_rst_zero8", 64'(zero8), 64'h1);
    check("async_rst_out32", 64'(out32), 64'h0);
    op(1'b1, 1'b1, 3'd6, 32'h0, 1'b0, 1'b0);
    op(1'b1, 1'b1, 3'd1, 32'hFF, 1'b0, 1'b0);
    op(1'b0, 1'b1, 3'd6, 32'h0, 1'b0, 1'b0);
    op(1'b0, 1'b1, 3'd6, 32'h0, 1'b0, 1'b0);

    // load then shift
    op(1'b0, 1'b1, 3'd1, 32'h81, 1'b0, 1'b0);
    op(1'b0, 1'b1, 3'd2, 32'h0, 1'b0, 1'b0);
    check("shl_0x81_n8", {55'd0, cout8, out8}, {55'd0, 1'b1, 8'h02});
    op(1'b0, 1'b1, 3'd3, 32'h0, 1'b0, 1'b1);
    check("shr_sl1_n8", {55'd0, cout8, out8}, {55'd0, 1'b0, 8'h81});

    // rotate right eight times
    op(1'b0, 1'b1, 3'd1, 32'h1, 1'b0, 1'b0);
    op(1'b0, 1'b1, 3'd5, 32'h0, 1'b1, 1'b1);
    check("ror_first_n8", {55'd0, cout8, out8}, {55'd0, 1'b1, 8'h80});
    for (int i = 0; i < 7; i++) op(1'b0, 1'b1, 3'd5, $urandom, 1'($urandom), 1'($urandom));
    check("ror_back_n8", 64'(out8), 64'h01);
    for (int i = 0; i < 4; i++) op(1'b0, 1'b1, 3'd4, $urandom, 1'($urandom), 1'($urandom));

    // counter wrap both ways
    op(1'b0, 1'b1, 3'd1, 32'hFFFFFFFF, 1'b0, 1'b0);
    op(1'b0, 1'b1, 3'd6, 32'h0, 1'b0, 1'b0);
    check("inc_wrap_n8", {54'd0, zero8, cout8, out8}, {54'd0, 1'b1, 1'b1, 8'h00});
    op(1'b0, 1'b1, 3'd7, 32'h0, 1'b0, 1'b0);
    check("dec_wrap_n8", {54'd0, zero8, cout8, out8}, {54'd0, 1'b0, 1'b1, 8'hFF});

    // enable low holds, hold mode holds
    for (int i = 0; i < 5; i++) op(1'b0, 1'b0, 3'd6, $urandom, 1'b1, 1'b1);
    op(1'b0, 1'b1, 3'd0, $urandom, 1'b1, 1'b1);
    check("hold_n8", {55'd0, cout8, out8}, {55'd0, 1'b1, 8'hFF});

    // random traffic with occasional reset
    for (int i = 0; i < 300; i++)
      op(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) != 0),
         3'($urandom), $urandom, 1'($urandom), 1'($urandom));

    for (int i = 0; i < 3 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nbit_universal_register.md
NBIT_UNIVERSAL_REGISTER -- requirements
Module: nbit_universal_register

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter: n, 8, data width in bits; legal range 2..64.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: en  input  1  operation enable; 0 = hold all state.
REQ-006 Port: mode  input  3  operation select (encoding in REQ-011).
REQ-007 Port: in0  input  n  parallel load data.
REQ-008 Port: sin_r  input  1  serial in, enters bit 0 on shift left.
REQ-009 Port: sin_l  input  1  serial in, enters bit n-1 on shift right.
REQ-010 Port: out0  output  n  registered contents; cout  output  1  registered carry/shift-out; zero  output  1  combinational, 1 when out0 == 0.

Function
REQ-011 mode encoding: 000 hold, 001 load, 010 shift left, 011 shift right, 100 rotate left, 101 rotate right, 110 increment, 111 decrement.
REQ-012 All state (out0, cout) SHALL update only on the rising clk edge with en=1 and rst=0; one-cycle latency, with the new value visible after that edge.
REQ-013 en=0 SHALL hold out0 and cout regardless of mode.
REQ-014 Hold: out0 and cout unchanged.
REQ-015 Load: out0 <= in0; cout <= 0.
REQ-016 Shift left: out0 <= {out0[n-2:0], sin_r}; cout <= old out0[n-1].
REQ-017 Shift right: out0 <= {sin_l, out0[n-1:1]}; cout <= old out0[0].
REQ-018 Rotate left: out0 <= {out0[n-2:0], out0[n-1]}; cout <= old out0[n-1]; serial inputs ignored.
REQ-019 Rotate right: out0 <= {out0[0], out0[n-1:1]}; cout <= old out0[0]; serial inputs ignored.
REQ-020 Increment: {cout, out0} <= out0 + 1 (n+1-bit result); wrap from all-ones to 0 SHALL set cout=1, otherwise cout=0.
REQ-021 Decrement: out0 <= out0 - 1 modulo 2^n; cout (borrow) SHALL be 1 only when old out0 == 0, with wrap to all-ones.
REQ-022 zero SHALL be purely combinational from out0 with no added latency; it SHALL not depend on mode, en, or inputs.
REQ-023 mode and data inputs SHALL be sampled only at the clock edge; changes between edges SHALL have no effect on out0 or cout.
REQ-024 The block SHALL be implemented as n per-bit flip-flop slices plus shared next-state logic, and SHALL scale with n without per-width code changes.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for clk, force out0=0 and cout=0; zero SHALL therefore read 1.
REQ-026 While rst=1, clk edges SHALL be ignored whatever the values of en and mode.
REQ-027 Reset asserted mid-sequence, for example during a run of increments, SHALL discard the operation in progress; the first enabled edge after rst falls SHALL operate on out0=0.
REQ-028 rst deassertion SHALL be treated as synchronous to clk by the environment; the block requires no internal reset synchroniser.

Verification
REQ-029 Reset: assert rst between edges with out0=0xA5 -> out0=0x00, cout=0, zero=1 before the next edge.
REQ-030 Load then shift: n=8, load 0x81; shift left with sin_r=0 -> out0=0x02, cout=1; shift right with sin_l=1 -> out0=0x81, cout=0.
REQ-031 Rotate: load 0x01, then 8 rotate-right edges -> out0 returns to 0x01; the first edge gives 0x80 with cout=1.
REQ-032 Counter wrap: load 0xFF, increment -> out0=0x00, cout=1, zero=1; decrement -> out0=0xFF, cout=1, zero=0.
REQ-033 Enable and hold: en=0 with mode=110 for 5 edges -> out0 and cout unchanged; mode=000 with en=1 -> unchanged.
REQ-034 Parameter sweep: repeat REQ-030 to REQ-032 at n=2 and n=32 against a reference model, with zero checked every cycle.
